uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter START_CYCLES, default 2: tx_start pulse width in clocks, minimum 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum clocks to wait for busy to rise.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte-pending flag, held until acked.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i captured.
REQ-009 SHALL have port tx_start  output  1  start strobe to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-011 SHALL have port busy  input  1  UART transmitter busy flag.
REQ-012 SHALL have port grant_id  output  3  index of the requester currently granted.
REQ-013 SHALL have port active  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port timeout_err  output  1  sticky: busy never rose within TIMEOUT_CYCLES (macro-dependent).

Function
REQ-015 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-016 In IDLE with any req_valid bit set, SHALL at the next edge: choose winner, latch its byte into tx_data, set grant_id, pulse req_ack[winner] for exactly one cycle, enter START.
REQ-017 Winner selection SHALL be round-robin: search begins at last-granted index + 1, wrapping from NUM_REQ-1 to 0.
REQ-018 Round-robin pointer SHALL update only on a grant; requesters dropping req_valid without a grant SHALL not move it.
REQ-019 In START, tx_start SHALL be high for exactly START_CYCLES consecutive cycles, then low; tx_data SHALL stay stable from grant until return to IDLE.
REQ-020 If busy is sampled high during START, SHALL go directly to WAIT_DONE after the pulse; otherwise to WAIT_BUSY.
REQ-021 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle busy is sampled high.
REQ-022 WAIT_DONE SHALL go to IDLE on the first cycle busy is sampled low.
REQ-023 New grants SHALL occur only from IDLE; minimum spacing between consecutive tx_start rising edges is START_CYCLES + 2 cycles.
REQ-024 req_valid/req_data changes while not in IDLE SHALL not affect the transfer in flight.
REQ-025 Simultaneous req_valid bits SHALL yield exactly one req_ack bit high per grant.
REQ-026 req_data of a non-granted requester SHALL never reach tx_data.

Reset
REQ-027 reset SHALL be sampled on the rising clk edge only, overriding all other inputs.
REQ-028 On reset: state IDLE, tx_start 0, tx_data 0x00, req_ack 0, grant_id 0, active 0, timeout_err 0, pointer set so requester 0 wins first.
REQ-029 reset asserted mid-transfer SHALL drop tx_start the following cycle; no req_ack SHALL be issued while reset is high.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: a counter in WAIT_BUSY SHALL, after TIMEOUT_CYCLES cycles without busy high, return to IDLE and set timeout_err until reset.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: WAIT_BUSY SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-032 Single request: req_valid[0]=1, req_data=0xA5 -> one req_ack[0] pulse, tx_data=0xA5, tx_start high exactly 2 cycles, active low after busy falls.
REQ-033 All four requesters valid with 0x11/0x22/0x33/0x44, held after each ack -> grant order 0,1,2,3,0; each byte appears on tx_data once per round.
REQ-034 After grant to 2, requesters 1 and 3 valid -> next grant is 3, then 1.
REQ-035 busy asserted in the second START cycle -> FSM skips WAIT_BUSY; IDLE reached on the cycle after busy falls.
REQ-036 UART_ARB_TIMEOUT_EN defined, busy held 0 -> timeout_err rises 64 cycles into WAIT_BUSY, FSM returns to IDLE, next request still served.
REQ-037 reset pulsed one cycle during WAIT_DONE with req_valid[1]=1 -> all outputs at reset values; first grant after reset goes to requester 1, not the interrupted requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that hands one byte at a time from
// NUM_REQ requesters to a single UART transmitter via a start strobe and
// waits for the transmitter's busy handshake before granting again.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- when defined, WAIT_BUSY
// gives up after TIMEOUT_CYCLES clocks and sets the sticky timeout_err.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   active,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: illegal parameter value");
  end

  state_t               state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           ptr_q, ptr_d;
  logic                 active_q, active_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic                 seen_q, seen_d;

  logic                 hit;
  logic [2:0]           win;
  logic [NUM_REQ-1:0]   vscan;
  logic [8*NUM_REQ-1:0] dscan;
  logic [7:0]           win_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_err_q, tmo_err_d;
`endif

  // Round-robin search: indices above the last grant first, then wrap to 0.
  always_comb begin
    hit   = 1'b0;
    win   = '0;
    vscan = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      vscan = req_valid >> j;
      if (!hit && (j > 32'(ptr_q)) && vscan[0]) begin
        hit = 1'b1;
        win = 3'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      vscan = req_valid >> j;
      if (!hit && (j <= 32'(ptr_q)) && vscan[0]) begin
        hit = 1'b1;
        win = 3'(j);
      end
    end
    dscan    = req_data >> (8 * 32'(win));
    win_byte = dscan[7:0];
  end

  // Next-state and next-output logic for the grant/start/handshake sequence.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    scnt_d     = scnt_q;
    seen_d     = seen_q;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = START;
          tx_start_d = 1'b1;
          tx_data_d  = win_byte;
          grant_d    = win;
          ptr_d      = win;
          ack_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          scnt_d     = '0;
          seen_d     = 1'b0;
        end
      end
      START: begin
        // busy may rise during any strobe cycle; remember it so the
        // WAIT_BUSY phase is skipped once the strobe completes.
        seen_d = seen_q | busy;
        if (scnt_q == SCW'(START_CYCLES - 1)) begin
          tx_start_d = 1'b0;
          state_d    = (seen_q | busy) ? WAIT_DONE : WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  // State and registered outputs; reset makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= 3'(NUM_REQ - 1);
      active_q   <= 1'b0;
      scnt_q     <= '0;
      seen_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      active_q   <= active_d;
      scnt_q     <= scnt_d;
      seen_q     <= seen_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign req_ack  = ack_q;
  assign grant_id = grant_q;
  assign active   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed-vector bench for uart_tx_arbiter with
// hand-computed expectations (default parameters: 4 requesters,
// 2-cycle start strobe, 64-cycle timeout).
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = 32'h44332211;
  logic [N-1:0]   req_ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           busy = 1'b0;
  logic [2:0]     grant_id;
  logic           active;
  logic           timeout_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .START_CYCLES(2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_txs", 32'(tx_start), 32'd0);
    check_eq("rst_txd", 32'(tx_data), 32'h00);
    check_eq("rst_ack", 32'(req_ack), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    check_eq("rst_act", 32'(active), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full transfer with busy rising after the strobe (WAIT_BUSY path).
  task automatic serve(input int unsigned id, input logic [7:0] bval, input bit drop);
    tick();
    check_eq("ack", 32'(req_ack), 32'(1) << id);
    check_eq("gid", 32'(grant_id), id);
    check_eq("txd", 32'(tx_data), 32'(bval));
    check_eq("start_c1", 32'(tx_start), 32'd1);
    check_eq("act_c1", 32'(active), 32'd1);
    if (drop) req_valid = '0;
    tick();
    check_eq("start_c2", 32'(tx_start), 32'd1);
    check_eq("ack_c2", 32'(req_ack), 32'd0);
    tick();
    check_eq("start_off", 32'(tx_start), 32'd0);
    check_eq("act_wb", 32'(active), 32'd1);
    busy = 1'b1;
    tick();
    check_eq("act_wd", 32'(active), 32'd1);
    check_eq("txd_wd", 32'(tx_data), 32'(bval));
    busy = 1'b0;
    tick();
    check_eq("act_idle", 32'(active), 32'd0);
    check_eq("txd_idle", 32'(tx_data), 32'(bval));
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals();

    // Single request from requester 0.
    req_data  = 32'h000000A5;
    req_valid = 4'b0001;
    serve(0, 8'hA5, 1'b1);

    // All four held valid: 0,1,2,3,0.
    do_reset();
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    serve(0, 8'h11, 1'b0);
    serve(1, 8'h22, 1'b0);
    serve(2, 8'h33, 1'b0);
    serve(3, 8'h44, 1'b0);
    serve(0, 8'h11, 1'b0);
    req_valid = '0;

    // After grant to 2, requesters 1 and 3 pending: 3 then 1.
    do_reset();
    req_valid = 4'b0100;
    serve(2, 8'h33, 1'b1);
    req_valid = 4'b1010;
    serve(3, 8'h44, 1'b0);
    serve(1, 8'h22, 1'b1);

    // busy rises in the second strobe cycle: WAIT_BUSY skipped.
    req_valid = 4'b0001;
    tick();
    check_eq("sk_ack", 32'(req_ack), 32'b0001);
    req_valid = '0;
    tick();
    check_eq("sk_start2", 32'(tx_start), 32'd1);
    busy = 1'b1;
    tick();
    check_eq("sk_start_off", 32'(tx_start), 32'd0);
    check_eq("sk_act", 32'(active), 32'd1);
    // Inputs changing mid-transfer must not disturb it.
    req_data  = 32'hFFFFFFFF;
    req_valid = 4'b1111;
    tick();
    check_eq("sk_txd_stable", 32'(tx_data), 32'h11);
    check_eq("sk_no_ack", 32'(req_ack), 32'd0);
    check_eq("sk_act_wd", 32'(active), 32'd1);
    req_valid = '0;
    req_data  = 32'h44332211;
    busy = 1'b0;
    tick();
    check_eq("sk_idle", 32'(active), 32'd0);

    // Reset during the start strobe drops tx_start next cycle.
    req_valid = 4'b0010;
    tick();
    check_eq("rs_start", 32'(tx_start), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rs_start_drop", 32'(tx_start), 32'd0);
    check_eq("rs_ack", 32'(req_ack), 32'd0);
    check_eq("rs_act", 32'(active), 32'd0);
    reset = 1'b0;
    req_valid = '0;

    // Reset in WAIT_DONE with requester 1 pending: next grant goes to 1.
    do_reset();
    req_valid = 4'b0001;
    tick();
    check_eq("rd_ack0", 32'(req_ack), 32'b0001);
    req_valid = '0;
    tick();
    busy = 1'b1;
    tick();
    tick();
    check_eq("rd_act_wd", 32'(active), 32'd1);
    req_valid = 4'b0010;
    reset = 1'b1;
    tick();
    check_reset_vals();
    tick();
    check_eq("rd_ack_in_rst", 32'(req_ack), 32'd0);
    reset = 1'b0;
    busy = 1'b0;
    tick();
    check_eq("rd_ack1", 32'(req_ack), 32'b0010);
    check_eq("rd_gid1", 32'(grant_id), 32'd1);
    check_eq("rd_txd1", 32'(tx_data), 32'h22);
    req_valid = '0;
    tick();
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check_eq("rd_idle", 32'(active), 32'd0);

    // busy never rises after the strobe.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("to_wb", 32'(active), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (63) tick();
    check_eq("to_pre_err", 32'(timeout_err), 32'd0);
    check_eq("to_pre_act", 32'(active), 32'd1);
    tick();
    check_eq("to_err", 32'(timeout_err), 32'd1);
    check_eq("to_idle", 32'(active), 32'd0);
    req_valid = 4'b0010;
    tick();
    check_eq("to_next_ack", 32'(req_ack), 32'b0010);
    check_eq("to_next_txd", 32'(tx_data), 32'h22);
    req_valid = '0;
    tick();
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check_eq("to_next_idle", 32'(active), 32'd0);
    check_eq("to_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (100) tick();
    check_eq("nt_still_wait", 32'(active), 32'd1);
    check_eq("nt_err", 32'(timeout_err), 32'd0);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check_eq("nt_idle", 32'(active), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
